alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Clock and reset SHALL be one clock (clk) and an asynchronous, active-high reset (reset).
REQ-002 Ports (name  direction  width  meaning), in this order:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous active-high reset
 instr_valid  in  1  instruction offered
 instr_ready  out  1  sequencer can accept an instruction
 instr_op  in  5  ALU opcode (ADD=00000 .. ARSH=10110, NOP=10111)
 instr_rdest  in  4  destination/first-operand register index
 instr_rsrc  in  4  source register index
 instr_imm  in  8  immediate
 rf_raddr_a  out  4  register file read port A address (rdest)
 rf_raddr_b  out  4  register file read port B address (rsrc)
 rf_rdata_a  in  16  read data A, valid one cycle after address
 rf_rdata_b  in  16  read data B, valid one cycle after address
 rf_we  out  1  register file write enable
 rf_waddr  out  4  write address
 rf_wdata  out  16  write data
 alu_a  out  16  ALU Rdest operand
 alu_b  out  16  ALU Rsrc operand
 alu_op  out  5  ALU opcode
 alu_cin  out  1  ALU carry in
 alu_out  in  16  ALU result (combinational)
 alu_flags  in  5  ALU flags {C,L,F,Z,N}
 psr  out  5  processor status register {C,L,F,Z,N}
 done  out  1  one-cycle completion pulse
 illegal  out  1  one-cycle pulse with done for opcodes 11000-11111

Function
REQ-003 FSM states SHALL be IDLE, READ, EXEC, WB; transitions IDLE->READ on instr_valid&instr_ready, READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-004 instr_ready SHALL be 1 only in IDLE; op, rdest, rsrc, imm SHALL be latched on the accept edge, and input changes after acceptance SHALL have no effect.
REQ-005 In READ, rf_raddr_a SHALL equal latched rdest and rf_raddr_b latched rsrc; both SHALL be 0 in other states.
REQ-006 In EXEC, alu_a SHALL be rf_rdata_a, alu_op the latched op, and alu_b rf_rdata_b for register ops or the extended immediate for immediate ops; alu_a, alu_b, alu_op and alu_cin SHALL be 0 outside EXEC.
REQ-007 Immediate ops SHALL be ADDI, ADDUI, ADDCUI, ADDCI, SUBI, CMPI, CMPUI, LSHI, RSHI; ADDI, ADDCI, SUBI and CMPI SHALL sign-extend imm[7:0] to 16 bits, and all other immediate ops SHALL zero-extend.
REQ-008 alu_cin SHALL be psr[4] (C) for ADDC, ADDCU, ADDCUI, ADDCI in EXEC, else 0.
REQ-009 At the end of EXEC, alu_out and alu_flags SHALL be captured into internal result and flag registers.
REQ-010 In WB, rf_we SHALL be 1, rf_waddr latched rdest, and rf_wdata the captured result, for every legal op except CMP, CMPI, CMPUI and NOP; otherwise rf_we SHALL be 0.
REQ-011 At the end of WB, psr SHALL load the captured flags for ADD..ADDCI, SUB, SUBI, CMP, CMPI, CMPUI (00000-01100); logic, shift, NOP and illegal ops SHALL leave psr unchanged.
REQ-012 done SHALL be 1 exactly in WB; illegal SHALL be 1 in WB when the op is >= 11000, and illegal ops SHALL perform no write or psr update.
REQ-013 Latency SHALL be 3 cycles from the accept edge to the WB cycle; throughput SHALL be one instruction per 4 cycles, and instr_valid held high SHALL re-accept in the cycle after WB.
REQ-014 A carry op following a flag-setting op SHALL see the psr value written by that op's WB.
REQ-015 rf_we, done and illegal SHALL never be asserted outside WB.

Reset
REQ-016 reset SHALL asynchronously force IDLE, psr=0, latched fields, result and flags = 0, and all outputs 0 except instr_ready=1.
REQ-017 Reset during READ, EXEC or WB SHALL abort the instruction with no register write and no psr update, including during WB.

Verification
REQ-018 R1=0x0005, R2=0x0003, ADD rdest=1 rsrc=2 -> done 3 cycles after accept, rf_we with waddr=1, wdata=0x0008, psr C=0, Z=0.
REQ-019 ADDI rdest=1 imm=0xFF with R1=0x0001 -> alu_b=0xFFFF, wdata=0x0000, psr Z=1, C=1; ADDUI with the same operands -> alu_b=0x00FF, wdata=0x0100.
REQ-020 R1=0x0004, CMPI imm=0x04 -> rf_we stays 0, psr Z=1; next ADDC R1+R1 with C=1 in psr -> alu_cin=1, wdata=0x0009.
REQ-021 instr_valid held high with 3 back-to-back ops -> instr_ready pulses every 4 cycles, 3 done pulses, and inputs changed mid-operation are ignored.
REQ-022 op=11010 -> done and illegal both 1 in WB, rf_we=0, psr unchanged.
REQ-023 reset asserted in the WB cycle -> rf_we drops immediately, psr=0, instr_ready=1 the same cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Four-state sequencer that steps one instruction through register read,
// ALU execution and register write-back. An instruction is accepted only
// in IDLE. Its fields are latched on the accept edge, so later input changes
// have no effect. The register file has a one-cycle read latency, and the
// ALU is purely combinational.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   instr_valid/ready       instruction handshake (ready only in IDLE)
//   instr_op/rdest/rsrc/imm instruction fields
//   rf_raddr_a/b            read addresses (READ state only)
//   rf_rdata_a/b            read data, valid the cycle after the address
//   rf_we/waddr/wdata       register write port (WB state only)
//   alu_a/b/op/cin          ALU operands (EXEC state only)
//   alu_out/alu_flags       ALU result and flags {C,L,F,Z,N}
//   psr                     processor status register {C,L,F,Z,N}
//   done                    completion pulse in WB
//   illegal                 pulse with done for opcodes 11000-11111
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  instr_op,
  input  logic [3:0]  instr_rdest,
  input  logic [3:0]  instr_rsrc,
  input  logic [7:0]  instr_imm,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal
);

  localparam logic [4:0] OP_ADDI          = 5'b00001;
  localparam logic [4:0] OP_ADDUI         = 5'b00011;
  localparam logic [4:0] OP_ADDC          = 5'b00100;
  localparam logic [4:0] OP_ADDCU         = 5'b00101;
  localparam logic [4:0] OP_ADDCUI        = 5'b00110;
  localparam logic [4:0] OP_ADDCI         = 5'b00111;
  localparam logic [4:0] OP_SUBI          = 5'b01001;
  localparam logic [4:0] OP_CMP           = 5'b01010;
  localparam logic [4:0] OP_CMPI          = 5'b01011;
  localparam logic [4:0] OP_CMPUI         = 5'b01100;
  localparam logic [4:0] OP_LSHI          = 5'b10010;
  localparam logic [4:0] OP_RSHI          = 5'b10100;
  localparam logic [4:0] OP_NOP           = 5'b10111;
  localparam logic [4:0] OP_FIRST_ILLEGAL = 5'b11000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  op_q;
  logic [3:0]  rdest_q;
  logic [3:0]  rsrc_q;
  logic [7:0]  imm_q;
  logic [15:0] result_q;
  logic [4:0]  flags_q;

  logic        is_imm;
  logic        is_signed_imm;
  logic        is_carry;
  logic        is_legal;
  logic        writes_rf;
  logic        sets_psr;
  logic [15:0] imm_ext;

  // Decode the latched opcode. This decides the source of the second
  // operand and whether carry-in is used. It also decides whether WB writes
  // the register file or the status register. Compares only set flags.
  // Logic and shift ops only write the register. Illegal opcodes do neither.
  always_comb begin
    is_imm        = 1'b0;
    is_signed_imm = 1'b0;
    is_carry      = 1'b0;
    case (op_q)
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
        is_imm        = 1'b1;
        is_signed_imm = 1'b1;
      end
      OP_ADDUI, OP_ADDCUI, OP_CMPUI, OP_LSHI, OP_RSHI: begin
        is_imm = 1'b1;
      end
      default: begin
      end
    endcase
    if (op_q == OP_ADDC || op_q == OP_ADDCU || op_q == OP_ADDCUI || op_q == OP_ADDCI) begin
      is_carry = 1'b1;
    end
    is_legal  = (op_q < OP_FIRST_ILLEGAL);
    sets_psr  = (op_q <= OP_CMPUI);
    writes_rf = is_legal && (op_q != OP_CMP) && (op_q != OP_CMPI) &&
                (op_q != OP_CMPUI) && (op_q != OP_NOP);
    imm_ext   = is_signed_imm ? {{8{imm_q[7]}}, imm_q} : {8'h00, imm_q};
  end

  // State register. Reset aborts any instruction in flight, including one
  // in WB, because the write enable is decoded from this state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the instruction fields on the accept edge only. The sequencer is
  // ready only in IDLE, so a held instr_valid cannot overwrite a running
  // instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      rdest_q <= '0;
      rsrc_q  <= '0;
      imm_q   <= '0;
    end else if (state == IDLE && instr_valid) begin
      op_q    <= instr_op;
      rdest_q <= instr_rdest;
      rsrc_q  <= instr_rsrc;
      imm_q   <= instr_imm;
    end
  end

  // Capture the ALU result and flags at the end of EXEC. WB then drives
  // stable values even though the ALU operands return to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state == EXEC) begin
      result_q <= alu_out;
      flags_q  <= alu_flags;
    end
  end

  // The status register updates at the end of WB. A carry op accepted right
  // after a flag-setting op reads this updated value in its own EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr <= '0;
    end else if (state == WB && sets_psr) begin
      psr <= flags_q;
    end
  end

  // Next-state and output decode. Every output defaults to zero, so each
  // output is active only in the state that owns it.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    alu_cin     = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = READ;
        end
      end
      READ: begin
        rf_raddr_a = rdest_q;
        rf_raddr_b = rsrc_q;
        state_next = EXEC;
      end
      EXEC: begin
        alu_a      = rf_rdata_a;
        alu_b      = is_imm ? imm_ext : rf_rdata_b;
        alu_op     = op_q;
        alu_cin    = is_carry ? psr[4] : 1'b0;
        state_next = WB;
      end
      WB: begin
        done    = 1'b1;
        illegal = ~is_legal;
        if (writes_rf) begin
          rf_we    = 1'b1;
          rf_waddr = rdest_q;
          rf_wdata = result_q;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
